// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_W data bits LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the serialiser.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_ready,
  output logic              o_tx_out,
  output logic              o_tx_busy,
  output logic              o_tx_done
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int               IDX_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  if ((DATA_W < 5) || (DATA_W > 9) || (CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535) ||
      (PARITY_MODE < 0) || (PARITY_MODE > 2) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_cfg
    $error("uart_tx_param: illegal parameter set");
  end

  // Even parity is the XOR of the data bits; odd parity is its complement.
  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    parity_of = (PARITY_MODE == 2) ? ~(^d) : (^d);
  endfunction

  state_t            r_state, w_state_n;
  logic [CNT_W-1:0]  r_cnt, w_cnt_n;
  logic [IDX_W-1:0]  r_idx, w_idx_n;
  logic              r_stop, w_stop_n;
  logic [DATA_W-1:0] r_data;
  logic              r_par;
  logic              r_tx_ready, r_tx_out, r_tx_busy, r_tx_done;
  logic              w_load, w_avail, w_bit_end, w_out_n, w_done_n, w_ready_n;
  logic [DATA_W-1:0] w_word;

`ifdef UART_TX_FIFO_EN
  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT1_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count, w_count_n;
  logic              w_push;

  assign w_push    = i_tx_valid & r_tx_ready;
  assign w_avail   = (r_count != {(PTR_W + 1){1'b0}});
  assign w_word    = r_mem[r_rd_ptr];
  assign w_ready_n = (w_count_n != FIFO_FULL);

  // Occupancy after this cycle's push (handshake) and pop (FSM load).
  always_comb begin
    w_count_n = r_count;
    if (w_push && !w_load) begin
      w_count_n = r_count + CNT1_ONE;
    end else if (!w_push && w_load) begin
      w_count_n = r_count - CNT1_ONE;
    end else begin
      w_count_n = r_count;
    end
  end

  // FIFO storage needs no reset; occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_tx_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W + 1){1'b0}};
    end else begin
      r_count <= w_count_n;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end
`else
  assign w_avail   = i_tx_valid & r_tx_ready;
  assign w_word    = i_tx_data;
  assign w_ready_n = (w_state_n == S_IDLE) | w_done_n;
`endif

  assign w_bit_end = (r_cnt == CNT_LAST);

  // Next-state logic; a word available in the final stop cycle chains straight into START.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_stop_n  = r_stop;
    w_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = CNT_ZERO;
        if (w_avail) begin
          w_load    = 1'b1;
          w_state_n = S_START;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_cnt_n   = CNT_ZERO;
          w_state_n = S_DATA;
        end else begin
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_n = CNT_ZERO;
          if (r_idx == IDX_LAST) begin
            w_idx_n   = IDX_ZERO;
            w_state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_n = r_idx + IDX_ONE;
          end
        end else begin
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_cnt_n   = CNT_ZERO;
          w_state_n = S_STOP;
        end else begin
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_cnt_n = CNT_ZERO;
          if (r_stop == STOP_LAST) begin
            w_stop_n = 1'b0;
            if (w_avail) begin
              w_load    = 1'b1;
              w_state_n = S_START;
            end else begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_stop_n = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = CNT_ZERO;
        w_idx_n   = IDX_ZERO;
        w_stop_n  = 1'b0;
      end
    endcase
  end

  // Line level for the upcoming cycle, so o_tx_out comes straight from a flop.
  always_comb begin
    w_out_n = 1'b1;
    if (w_state_n == S_START) begin
      w_out_n = 1'b0;
    end else if (w_state_n == S_DATA) begin
      w_out_n = r_data[w_idx_n];
    end else if (w_state_n == S_PARITY) begin
      w_out_n = r_par;
    end else begin
      w_out_n = 1'b1;
    end
  end

  assign w_done_n = (w_state_n == S_STOP) && (w_stop_n == STOP_LAST) && (w_cnt_n == CNT_LAST);

  // FSM, latched word and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_idx      <= IDX_ZERO;
      r_stop     <= 1'b0;
      r_data     <= {DATA_W{1'b0}};
      r_par      <= 1'b0;
      r_tx_ready <= 1'b0;
      r_tx_out   <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_stop     <= w_stop_n;
      r_tx_ready <= w_ready_n;
      r_tx_out   <= w_out_n;
      r_tx_busy  <= (w_state_n != S_IDLE);
      r_tx_done  <= w_done_n;
      if (w_load) begin
        r_data <= w_word;
        r_par  <= parity_of(w_word);
      end
    end
  end

  assign o_tx_ready = r_tx_ready;
  assign o_tx_out   = r_tx_out;
  assign o_tx_busy  = r_tx_busy;
  assign o_tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: five instances with different frame formats,
// each line compared cycle by cycle against a frame model built from the word.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int N = 5;
  localparam int DW  [N] = '{8, 8, 8, 8, 5};
  localparam int CPB [N] = '{4, 4, 4, 4, 2};
  localparam int PM  [N] = '{0, 1, 2, 0, 0};
  localparam int SB  [N] = '{1, 1, 1, 2, 1};
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int BURST1 = (LAT == 0) ? 1 : 0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] valid = '0;
  logic [8:0]   data [N];
  logic [N-1:0] ready, line, busy, done;
  logic [8:0]   wq [$];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_param #(
      .DATA_W(DW[g]), .CLKS_PER_BIT(CPB[g]), .PARITY_MODE(PM[g]),
      .STOP_BITS(SB[g]), .FIFO_DEPTH(4)
    ) u_dut (
      .i_clk(clk), .i_reset(rst), .i_tx_valid(valid[g]), .i_tx_data(data[g][DW[g]-1:0]),
      .o_tx_ready(ready[g]), .o_tx_out(line[g]), .o_tx_busy(busy[g]), .o_tx_done(done[g])
    );
  end

  // Offer every word of wq to instance k with valid held, and check the whole line stream.
  task automatic run_words(input int k, input int exp_burst, input string name);
    bit exp[$];
    int cpb = CPB[k];
    int f = (1 + DW[k] + ((PM[k] != 0) ? 1 : 0) + SB[k]) * cpb;
    int total, nacc, first, burst, pos, ones;
    bit r, finished;
    nacc = 0; first = -1; burst = -1; finished = 0;
    foreach (wq[j]) begin
      ones = 0;
      exp.push_back(1'b0);
      for (int i = 0; i < DW[k]; i++) begin
        exp.push_back(wq[j][i]);
        ones += int'(wq[j][i]);
      end
      if (PM[k] == 1) exp.push_back(bit'(ones % 2));
      else if (PM[k] == 2) exp.push_back(bit'((ones + 1) % 2));
      for (int i = 0; i < SB[k]; i++) exp.push_back(1'b1);
    end
    total = wq.size() * f;
    for (int cyc = 0; cyc < total + 40 && !finished; cyc++) begin
      if (nacc < wq.size()) begin
        valid[k] = 1'b1;
        data[k]  = wq[nacc];
      end else begin
        valid[k] = 1'b0;
      end
      r = ready[k];
      @(posedge clk); #1;
      if (valid[k] && r) begin
        if (nacc == 0) first = cyc;
        nacc++;
      end
      if (burst < 0 && nacc > 0 && !ready[k]) burst = nacc;
      if (first >= 0 && cyc >= first + LAT) begin
        pos = cyc - first - LAT;
        if (pos < total) begin
          checks++;
          if (line[k] !== exp[pos / cpb]) begin
            errors++;
            $display("FAIL %s line dut%0d cycle %0d: got %b expected %b", name, k, pos, line[k], exp[pos / cpb]);
          end
          checks++;
          if (busy[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy dut%0d cycle %0d: got %b expected 1", name, k, pos, busy[k]);
          end
          checks++;
          if (done[k] !== ((pos % f) == f - 1)) begin
            errors++;
            $display("FAIL %s done dut%0d cycle %0d: got %b expected %b", name, k, pos, done[k], (pos % f) == f - 1);
          end
        end else begin
          checks++;
          if ({line[k], busy[k], done[k]} !== 3'b100) begin
            errors++;
            $display("FAIL %s idle dut%0d: got line/busy/done %b expected 100", name, k, {line[k], busy[k], done[k]});
          end
          finished = 1'b1;
        end
      end
    end
    valid[k] = 1'b0;
    wq.delete();
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout dut%0d: accepted %0d words, stream incomplete", name, k, nacc);
    end
    if (exp_burst > 0) begin
      checks++;
      if (burst !== exp_burst) begin
        errors++;
        $display("FAIL %s ready_burst dut%0d: got %0d expected %0d", name, k, burst, exp_burst);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (line !== {N{1'b1}} || busy !== '0 || done !== '0 || ready !== '0) begin
      errors++;
      $display("FAIL reset_state: got line=%b busy=%b done=%b ready=%b expected 11111/0/0/0", line, busy, done, ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== {N{1'b1}}) begin
      errors++;
      $display("FAIL reset_release_ready: got %b expected 11111", ready);
    end
  endtask

  task automatic test_spec_vectors();
    wq.push_back(9'h0A5); run_words(0, BURST1, "a5_noparity");
    wq.push_back(9'h007); run_words(1, BURST1, "07_even");
    wq.push_back(9'h007); run_words(2, BURST1, "07_odd");
    wq.push_back(9'h015); run_words(4, BURST1, "15_w5");
  endtask

  task automatic test_back_to_back();
    wq.push_back(9'h000);
    wq.push_back(9'h0FF);
    run_words(3, BURST1, "b2b_2stop");
  endtask

  task automatic test_reset_mid_frame();
    valid[0] = 1'b1;
    data[0]  = 9'h03C;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    repeat (17 + LAT) @(posedge clk);
    #1;
    checks++;
    if (busy[0] !== 1'b1 || line[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_bit3: got busy=%b line=%b expected 1/1", busy[0], line[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (line[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0 || ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got line=%b busy=%b done=%b ready=%b expected 1/0/0/0", line[0], busy[0], done[0], ready[0]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready[0] !== 1'b1 || busy[0] !== 1'b0 || line[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: got ready=%b busy=%b line=%b expected 1/0/1", ready[0], busy[0], line[0]);
    end
    wq.push_back(9'h081);
    run_words(0, BURST1, "81_after_reset");
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo();
    for (int i = 0; i < 6; i++) wq.push_back(9'($urandom_range(0, 255)));
    run_words(0, 5, "fifo_six");
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 3; i++) wq.push_back(9'($urandom_range(0, (1 << DW[k]) - 1)));
      run_words(k, BURST1, "random");
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) data[k] = 9'h000;
    test_reset();
    test_spec_vectors();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_FIFO_EN
    test_fifo();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 868, clk cycles per bit period; legal range 2..65535.
REQ-003 Parameter PARITY_MODE, default 0, parity select: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, input FIFO entries; power of 2, 2..16; used only under UART_TX_FIFO_EN.
REQ-006 clk  input  1  single clock; all logic rising-edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 tx_valid  input  1  producer has a word on tx_data.
REQ-009 tx_data  input  DATA_W  word to transmit, sampled on handshake.
REQ-010 tx_ready  output  1  block accepts a word this cycle.
REQ-011 tx_out  output  1  serial line, idle high.
REQ-012 tx_busy  output  1  high while a frame is on the line.
REQ-013 tx_done  output  1  one-cycle pulse at end of last stop bit.

Function
REQ-014 Handshake: word accepted on a rising clk edge with tx_valid=1 and tx_ready=1; tx_data ignored otherwise.
REQ-015 FSM states: IDLE, START, DATA, PARITY, STOP; registered, one-hot or binary at implementer's choice.
REQ-016 IDLE: tx_out=1, tx_busy=0; on a word available (handshake, or non-empty FIFO), load shift register and go to START on the next edge.
REQ-017 Latency: tx_out falls on the first clk edge after the handshake cycle (no-FIFO build).
REQ-018 Each of START, each data bit, PARITY and each stop bit lasts exactly CLKS_PER_BIT cycles, timed by a bit counter of width clog2(CLKS_PER_BIT).
REQ-019 START: tx_out=0; DATA: DATA_W bits, LSB first; bit index counter wraps to 0 when leaving DATA.
REQ-020 PARITY: present only when PARITY_MODE!=0; even -> XOR of data bits; odd -> inverted XOR; skipped (DATA->STOP) when PARITY_MODE=0.
REQ-021 STOP: tx_out=1 for STOP_BITS bit periods; tx_done pulses for one cycle in the last cycle of the last stop bit.
REQ-022 Frame length = (1 + DATA_W + (PARITY_MODE!=0) + STOP_BITS) x CLKS_PER_BIT cycles.
REQ-023 Back-to-back: a pending word in the same cycle as tx_done goes directly STOP->START without an IDLE cycle; tx_out gap is zero extra cycles.
REQ-024 tx_busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
REQ-025 Parity is computed from the latched word, not from live tx_data.

Reset
REQ-026 reset=1 forces asynchronously: state IDLE, tx_out=1, tx_busy=0, tx_done=0, counters 0, FIFO empty.
REQ-027 reset during a frame aborts it; no partial frame resumes after release; tx_ready reasserts on the first edge after reset deasserts.

Configuration
REQ-028 Macro UART_TX_FIFO_EN selects the input buffer.
REQ-029 Defined: FIFO_DEPTH-entry FIFO between handshake and FSM; tx_ready = !full; FSM pops when IDLE or in tx_done cycle; push and pop in the same cycle when full is legal and keeps count unchanged; latency handshake->start bit is 2 edges.
REQ-030 Not defined: no FIFO; tx_ready = (state==IDLE) or tx_done cycle; single-word holding register only.

Verification
REQ-031 CLKS_PER_BIT=4, DATA_W=8, no parity, 1 stop, send 8'hA5 -> tx_out 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; tx_done pulse at cycle 40.
REQ-032 PARITY_MODE=1 send 8'h07 -> parity bit 1; PARITY_MODE=2 same word -> parity bit 0; frame 44 cycles.
REQ-033 STOP_BITS=2, two words 8'h00,8'hFF with tx_valid held -> second start bit begins cycle immediately after first tx_done; no idle gap.
REQ-034 Assert reset mid-DATA (bit 3 of 8'h3C) -> tx_out=1 same cycle, tx_busy=0; next word 8'h81 transmits a clean full frame.
REQ-035 UART_TX_FIFO_EN, FIFO_DEPTH=4, push 6 words back-to-back -> tx_ready low after 5th accepted (1 in flight + 4 buffered), all 5 accepted words serialised in order.
REQ-036 DATA_W=5, CLKS_PER_BIT=2, send 5'h15 -> 7-period frame, data bits 1,0,1,0,1.
